// File: rtl/pkg_instr_dec.sv
// Shared fetch/decode definitions: fetch FSM states, group 5 opcode identifier
// and the illegal-opcode predicate used by the optional detector.
package pkg_instr_dec;

   typedef enum logic [1:0] {
      RESET_WAIT = 2'd0,
      FETCH_HI   = 2'd1,
      FETCH_LO   = 2'd2,
      HOLD       = 2'd3
   } ifu_state;

   localparam int          GRP5_MSB = 15;
   localparam int          GRP5_LSB = 10;
   localparam logic [5:0]  GRP5_ID  = 6'b111000;

   function automatic logic is_group5(input logic [15:0] word);
      return word[GRP5_MSB:GRP5_LSB] == GRP5_ID;
   endfunction

   // Group space is exhausted at 1111, and 1110 is only populated by group 5.
   function automatic logic is_illegal_word(input logic [15:0] word);
      return (word[15:12] == 4'b1111) ||
             ((word[15:12] == 4'b1110) && (word[11:10] != 2'b00));
   endfunction

endpackage

// File: rtl/instr_len_detector.sv
// Combinational length/legality classifier for the first instruction word.
// Illegal detection is only built when INSTR_FETCH_ILLEGAL_DET_EN is defined.
module instr_len_detector
   import pkg_instr_dec::*;
(
   input  logic [15:0] word,
   output logic        is_32,
   output logic        is_illegal
);

   assign is_32 = is_group5(word);

`ifdef INSTR_FETCH_ILLEGAL_DET_EN
   assign is_illegal = is_illegal_word(word);
`else
   assign is_illegal = 1'b0;
`endif

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: reads one or two words per instruction and hands it to decode.
// Optional illegal-opcode flag enabled by INSTR_FETCH_ILLEGAL_DET_EN.
module instr_fetch_unit
   import pkg_instr_dec::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000
)
(
   input  logic        clk,
   input  logic        rst_n,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   input  logic        mem_ack,
   input  logic [15:0] mem_rdata,
   input  logic        pc_load,
   input  logic [15:0] pc_load_val,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] instr_hi,
   output logic [15:0] instr_lo,
   output logic        instr_is_32,
   output logic [15:0] instr_pc,
   output logic        instr_illegal
);

   ifu_state    state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic        mem_req_q, mem_req_d;
   logic [15:0] mem_addr_q, mem_addr_d;
   logic        out_valid_q, out_valid_d;
   logic [15:0] instr_hi_q, instr_hi_d;
   logic [15:0] instr_lo_q, instr_lo_d;
   logic        instr_is_32_q, instr_is_32_d;
   logic [15:0] instr_pc_q, instr_pc_d;
   logic        instr_illegal_q, instr_illegal_d;

   logic        det_is_32;
   logic        det_illegal;

   instr_len_detector u_len_det (
      .word       (mem_rdata),
      .is_32      (det_is_32),
      .is_illegal (det_illegal)
   );

   always_comb begin
      state_d         = state_q;
      pc_d            = pc_q;
      instr_hi_d      = instr_hi_q;
      instr_lo_d      = instr_lo_q;
      instr_is_32_d   = instr_is_32_q;
      instr_pc_d      = instr_pc_q;
      instr_illegal_d = instr_illegal_q;

      case (state_q)
         RESET_WAIT: state_d = FETCH_HI;
         FETCH_HI: begin
            if (mem_ack) begin
               instr_hi_d      = mem_rdata;
               instr_lo_d      = 16'h0000;
               instr_pc_d      = pc_q;
               instr_is_32_d   = det_is_32;
               instr_illegal_d = det_illegal;
               pc_d            = pc_q + 16'd1;
               state_d         = det_is_32 ? FETCH_LO : HOLD;
            end
         end
         FETCH_LO: begin
            if (mem_ack) begin
               instr_lo_d = mem_rdata;
               pc_d       = pc_q + 16'd1;
               state_d    = HOLD;
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_d = FETCH_HI;
            end
         end
         default: state_d = RESET_WAIT;
      endcase

      // Redirect wins over everything, including a same-cycle memory ack.
      if (pc_load) begin
         pc_d            = pc_load_val;
         state_d         = FETCH_HI;
         instr_hi_d      = instr_hi_q;
         instr_lo_d      = instr_lo_q;
         instr_is_32_d   = instr_is_32_q;
         instr_pc_d      = instr_pc_q;
         instr_illegal_d = instr_illegal_q;
      end

      mem_req_d   = (state_d == FETCH_HI) || (state_d == FETCH_LO);
      mem_addr_d  = mem_req_d ? pc_d : 16'h0000;
      out_valid_d = (state_d == HOLD);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= RESET_WAIT;
         pc_q            <= RESET_PC;
         mem_req_q       <= 1'b0;
         mem_addr_q      <= 16'h0000;
         out_valid_q     <= 1'b0;
         instr_hi_q      <= 16'h0000;
         instr_lo_q      <= 16'h0000;
         instr_is_32_q   <= 1'b0;
         instr_pc_q      <= 16'h0000;
         instr_illegal_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         pc_q            <= pc_d;
         mem_req_q       <= mem_req_d;
         mem_addr_q      <= mem_addr_d;
         out_valid_q     <= out_valid_d;
         instr_hi_q      <= instr_hi_d;
         instr_lo_q      <= instr_lo_d;
         instr_is_32_q   <= instr_is_32_d;
         instr_pc_q      <= instr_pc_d;
         instr_illegal_q <= instr_illegal_d;
      end
   end

   assign mem_req       = mem_req_q;
   assign mem_addr      = mem_addr_q;
   assign out_valid     = out_valid_q;
   assign instr_hi      = instr_hi_q;
   assign instr_lo      = instr_lo_q;
   assign instr_is_32   = instr_is_32_q;
   assign instr_pc      = instr_pc_q;
   assign instr_illegal = instr_illegal_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: vector table plus hand sequences,
// with a scoreboard of expected instructions checked at each decode handoff.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [15:0] mem_rdata = 16'h0000;
   logic        pc_load;
   logic [15:0] pc_load_val;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] instr_hi;
   logic [15:0] instr_lo;
   logic        instr_is_32;
   logic [15:0] instr_pc;
   logic        instr_illegal;

`ifdef INSTR_FETCH_ILLEGAL_DET_EN
   localparam bit ILL_EN = 1'b1;
`else
   localparam bit ILL_EN = 1'b0;
`endif

   typedef struct {
      logic [15:0] hi;
      logic [15:0] lo;
      logic        is32;
      logic [15:0] pc;
      logic        ill;
   } exp_t;

   typedef struct {
      string       name;
      logic [15:0] start_pc;
      int          waits;
      logic [15:0] exp_hi;
      logic [15:0] exp_lo;
      logic        exp_is32;
      logic        exp_ill;
      logic [15:0] exp_next;
   } vec_t;

   exp_t sb[$];
   int   xfer_cycles[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;
   int   waits_n  = 0;
   int   wait_cnt = 0;
   vec_t vecs[6];

   instr_fetch_unit #(.RESET_PC(16'h0100)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .mem_req       (mem_req),
      .mem_addr      (mem_addr),
      .mem_ack       (mem_ack),
      .mem_rdata     (mem_rdata),
      .pc_load       (pc_load),
      .pc_load_val   (pc_load_val),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .instr_hi      (instr_hi),
      .instr_lo      (instr_lo),
      .instr_is_32   (instr_is_32),
      .instr_pc      (instr_pc),
      .instr_illegal (instr_illegal)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      case (a)
         16'h0100: return 16'h1234;
         16'h0200: return 16'hE0AB;
         16'h0201: return 16'h5566;
         16'hFFFF: return 16'hE0C3;
         16'h0000: return 16'h7788;
         16'h0300: return 16'hE3FF;
         16'h0301: return 16'h9999;
         16'h0500: return 16'hF000;
         16'h0580: return 16'hE400;
         16'h0A00: return 16'hE000;
         16'h0A01: return 16'h1111;
         16'h0A02: return 16'hE100;
         16'h0A03: return 16'h2222;
         16'h0A04: return 16'hE200;
         16'h0A05: return 16'h3333;
         default:  return {4'h2, a[11:0]};
      endcase
   endfunction

   // Instruction memory: answers after waits_n idle cycles, evaluated mid-cycle.
   always @(negedge clk) begin
      if (!mem_req) begin
         mem_ack  = 1'b0;
         wait_cnt = 0;
      end else if (wait_cnt >= waits_n) begin
         mem_ack   = 1'b1;
         mem_rdata = mem_word(mem_addr);
         wait_cnt  = 0;
      end else begin
         mem_ack = 1'b0;
         wait_cnt++;
      end
   end

   task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
   endtask

   // Handoff monitor: a transfer happens at the next rising edge.
   always @(negedge clk) begin
      exp_t e;
      #2;
      if (rst_n && out_valid && out_ready) begin
         xfer_cycles.push_back(cyc);
         n_checks++;
         if (sb.size() == 0) begin
            $display("[TB] FAIL sb_unexpected_xfer: got instr_hi %h at pc %h, want no transfer", instr_hi, instr_pc);
         end else begin
            n_pass++;
            e = sb.pop_front();
            check_output("sb_instr_hi", instr_hi, e.hi);
            check_output("sb_instr_lo", instr_lo, e.lo);
            check_output("sb_instr_is_32", {15'h0, instr_is_32}, {15'h0, e.is32});
            check_output("sb_instr_pc", instr_pc, e.pc);
            check_output("sb_instr_illegal", {15'h0, instr_illegal}, {15'h0, e.ill});
         end
      end
   end

   task automatic push_exp(input logic [15:0] hi, input logic [15:0] lo, input logic is32,
                           input logic [15:0] pc, input logic ill);
      exp_t e;
      e.hi = hi; e.lo = lo; e.is32 = is32; e.pc = pc; e.ill = ill;
      sb.push_back(e);
   endtask

   task automatic push_stream(input logic [15:0] start, input int n);
      logic [15:0] p;
      logic [15:0] hi;
      logic        g5;
      p = start;
      for (int k = 0; k < n; k++) begin
         hi = mem_word(p);
         g5 = (hi[15:10] == 6'b111000);
         push_exp(hi, g5 ? mem_word(p + 16'd1) : 16'h0000, g5, p,
                  ILL_EN && ((hi[15:12] == 4'hF) || ((hi[15:12] == 4'hE) && (hi[11:10] != 2'b00))));
         p = p + (g5 ? 16'd2 : 16'd1);
      end
   endtask

   task automatic redirect(input logic [15:0] target);
      @(negedge clk); #1;
      pc_load     = 1'b1;
      pc_load_val = target;
      @(posedge clk); #1;
      pc_load     = 1'b0;
   endtask

   task automatic wait_valid(input string name, input int budget);
      int i = 0;
      while (!out_valid && i < budget) begin
         @(negedge clk); #1;
         i++;
      end
      check_output(name, {15'h0, out_valid}, 16'h0001);
   endtask

   task automatic handoff();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic apply_stimulus(input vec_t v);
      waits_n   = v.waits;
      out_ready = 1'b0;
      push_exp(v.exp_hi, v.exp_lo, v.exp_is32, v.start_pc, v.exp_ill);
      redirect(v.start_pc);
      wait_valid({v.name, "_valid"}, 40);
      handoff();
      check_output({v.name, "_next_req"}, {15'h0, mem_req}, 16'h0001);
      check_output({v.name, "_next_addr"}, mem_addr, v.exp_next);
   endtask

   task automatic stream_test(input string name, input logic [15:0] start, input int n, input int spacing);
      int base;
      int i;
      waits_n   = 0;
      out_ready = 1'b0;
      push_stream(start, n);
      redirect(start);
      base      = xfer_cycles.size();
      out_ready = 1'b1;
      i = 0;
      while (xfer_cycles.size() < base + n && i < 200) begin
         @(negedge clk); #3;
         i++;
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      check_output({name, "_count"}, 16'(xfer_cycles.size() - base), 16'(n));
      for (int k = base + 1; k < xfer_cycles.size(); k++) begin
         check_output({name, "_spacing"}, 16'(xfer_cycles[k] - xfer_cycles[k-1]), 16'(spacing));
      end
   endtask

   initial begin
      bit found;

      vecs[0] = '{"vec_grp5",      16'h0200, 0, 16'hE0AB, 16'h5566, 1'b1, 1'b0,   16'h0202};
      vecs[1] = '{"vec_grp5_wait", 16'h0200, 2, 16'hE0AB, 16'h5566, 1'b1, 1'b0,   16'h0202};
      vecs[2] = '{"vec_wrap",      16'hFFFF, 0, 16'hE0C3, 16'h7788, 1'b1, 1'b0,   16'h0001};
      vecs[3] = '{"vec_f000",      16'h0500, 0, 16'hF000, 16'h0000, 1'b0, ILL_EN, 16'h0501};
      vecs[4] = '{"vec_e400",      16'h0580, 1, 16'hE400, 16'h0000, 1'b0, ILL_EN, 16'h0581};
      vecs[5] = '{"vec_one_wait",  16'h0600, 1, 16'h2600, 16'h0000, 1'b0, 1'b0,   16'h0601};

      rst_n       = 1'b1;
      out_ready   = 1'b1;
      pc_load     = 1'b0;
      pc_load_val = 16'h0000;
      #3 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check_output("rst_mem_req", {15'h0, mem_req}, 16'h0000);
      check_output("rst_mem_addr", mem_addr, 16'h0000);
      check_output("rst_out_valid", {15'h0, out_valid}, 16'h0000);
      check_output("rst_instr_hi", instr_hi, 16'h0000);
      check_output("rst_instr_lo", instr_lo, 16'h0000);
      check_output("rst_instr_is_32", {15'h0, instr_is_32}, 16'h0000);
      check_output("rst_instr_pc", instr_pc, 16'h0000);
      check_output("rst_instr_illegal", {15'h0, instr_illegal}, 16'h0000);

      // First fetch from RESET_PC with zero-wait memory and decode always ready.
      push_exp(16'h1234, 16'h0000, 1'b0, 16'h0100, 1'b0);
      rst_n = 1'b1;
      check_output("rst_wait_no_req", {15'h0, mem_req}, 16'h0000);
      @(posedge clk); #1;
      check_output("first_req", {15'h0, mem_req}, 16'h0001);
      check_output("first_addr", mem_addr, 16'h0100);
      @(posedge clk); #1;
      check_output("first_valid_timing", {15'h0, out_valid}, 16'h0001);
      @(posedge clk); #1;
      out_ready = 1'b0;
      check_output("first_xfer_count", 16'(xfer_cycles.size()), 16'd1);

      foreach (vecs[i]) apply_stimulus(vecs[i]);

      // Decode stalls for five cycles: outputs frozen, no memory traffic.
      waits_n = 0;
      redirect(16'h0700);
      wait_valid("hold_valid", 20);
      for (int k = 0; k < 5; k++) begin
         check_output("hold_out_valid", {15'h0, out_valid}, 16'h0001);
         check_output("hold_mem_req", {15'h0, mem_req}, 16'h0000);
         check_output("hold_instr_hi", instr_hi, 16'h2700);
         check_output("hold_instr_pc", instr_pc, 16'h0700);
         @(negedge clk); #1;
      end
      push_exp(16'h2700, 16'h0000, 1'b0, 16'h0700, 1'b0);
      handoff();
      check_output("hold_release_req", {15'h0, mem_req}, 16'h0001);
      check_output("hold_release_addr", mem_addr, 16'h0701);

      stream_test("tput_one_word", 16'h0800, 4, 2);
      stream_test("tput_grp5", 16'h0A00, 3, 3);

      // Redirect coinciding with the second-word ack of a group 5 fetch.
      out_ready = 1'b0;
      redirect(16'h0300);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk); #1;
         if (mem_req && mem_addr == 16'h0301) found = 1'b1;
      end
      check_output("lo_redirect_reached", {15'h0, found}, 16'h0001);
      pc_load     = 1'b1;
      pc_load_val = 16'h0400;
      @(posedge clk); #1;
      pc_load = 1'b0;
      check_output("lo_redirect_req", {15'h0, mem_req}, 16'h0001);
      check_output("lo_redirect_addr", mem_addr, 16'h0400);
      push_exp(16'h2400, 16'h0000, 1'b0, 16'h0400, 1'b0);
      wait_valid("lo_redirect_valid", 20);
      handoff();

      // Handoff and redirect in the same cycle: transfer completes, redirect applies.
      redirect(16'h0B00);
      wait_valid("xfer_redirect_valid", 20);
      push_exp(16'h2B00, 16'h0000, 1'b0, 16'h0B00, 1'b0);
      out_ready   = 1'b1;
      pc_load     = 1'b1;
      pc_load_val = 16'h0C00;
      @(posedge clk); #1;
      out_ready = 1'b0;
      pc_load   = 1'b0;
      check_output("xfer_redirect_req", {15'h0, mem_req}, 16'h0001);
      check_output("xfer_redirect_addr", mem_addr, 16'h0C00);
      push_exp(16'h2C00, 16'h0000, 1'b0, 16'h0C00, 1'b0);
      wait_valid("xfer_redirect_next_valid", 20);
      handoff();

      // Reset asserted while a slow fetch is outstanding.
      waits_n = 5;
      redirect(16'h0D00);
      check_output("midrst_req_before", {15'h0, mem_req}, 16'h0001);
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      check_output("midrst_mem_req", {15'h0, mem_req}, 16'h0000);
      check_output("midrst_mem_addr", mem_addr, 16'h0000);
      check_output("midrst_out_valid", {15'h0, out_valid}, 16'h0000);
      check_output("sb_drained", 16'(sb.size()), 16'd0);

      $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
